// File: rtl/alu_scheduler.sv
// Round-robin front end that shares one ALU among NREQ requesters. Divide-by-zero
// and illegal opcodes are answered directly and never reach the ALU.
module alu_scheduler #(
    parameter int NREQ       = 2,
    parameter int MULDIV_LAT = 4,
    parameter int IDW        = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [5*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_data1,
    input  logic [32*NREQ-1:0]   req_data2,
    input  logic [5*NREQ-1:0]    req_shamt,
    output logic [NREQ-1:0]      grant,
    output logic [31:0]          alu_data1,
    output logic [31:0]          alu_data2,
    output logic [4:0]           alu_op,
    output logic [4:0]           alu_shamt,
    input  logic [31:0]          alu_out,
    input  logic                 alu_zero,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic [31:0]          resp_data,
    output logic                 resp_zero,
    output logic                 resp_dz,
    output logic                 resp_ill,
    output logic                 busy
);
    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_MUL = 5'b01100;
    localparam logic [4:0] OP_DIV = 5'b01101;
    localparam logic [4:0] OP_REM = 5'b01110;
    localparam logic [4:0] OP_ILL = 5'b10100;
    localparam int CNTW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

    typedef enum logic {S_IDLE, S_EXEC} state_t;

    state_t           r_state, w_next;
    logic [IDW-1:0]   r_last, w_win;
    logic [CNTW-1:0]  r_cnt;
    logic             r_icpt, r_dz, r_ill;
    logic [31:0]      r_icpt_data;
    int               w_best, w_dist;
    logic [4:0]       w_op, w_shamt;
    logic [31:0]      w_d1, w_d2;
    logic             w_any, w_start, w_done, w_muldiv, w_dz, w_ill;

    // Winner is the set request at the smallest rotated distance past r_last.
    always_comb begin
        w_any   = |req;
        w_win   = '0;
        w_best  = NREQ;
        w_dist  = 0;
        w_op    = '0;
        w_shamt = '0;
        w_d1    = '0;
        w_d2    = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i + 2*NREQ - int'(r_last) - 1) % NREQ;
            if (req[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_win   = IDW'(i);
                w_op    = req_op[5*i +: 5];
                w_shamt = req_shamt[5*i +: 5];
                w_d1    = req_data1[32*i +: 32];
                w_d2    = req_data2[32*i +: 32];
            end
        end
    end

    assign w_muldiv = (w_op == OP_MUL) || (w_op == OP_DIV) || (w_op == OP_REM);
    assign w_dz     = ((w_op == OP_DIV) || (w_op == OP_REM)) && (w_d2 == 32'd0);
    assign w_ill    = (w_op >= OP_ILL);
    assign w_start  = (r_state == S_IDLE) && w_any;
    assign w_done   = (r_state == S_EXEC) && (r_cnt == '0);
    assign busy     = (r_state == S_EXEC);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any)  w_next = S_EXEC;
            S_EXEC:  if (w_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant       <= '0;
            alu_data1   <= '0;
            alu_data2   <= '0;
            alu_op      <= '0;
            alu_shamt   <= '0;
            r_last      <= IDW'(NREQ-1);
            r_cnt       <= '0;
            r_icpt      <= 1'b0;
            r_icpt_data <= '0;
            r_dz        <= 1'b0;
            r_ill       <= 1'b0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_data   <= '0;
            resp_zero   <= 1'b0;
            resp_dz     <= 1'b0;
            resp_ill    <= 1'b0;
        end else begin
            grant      <= '0;
            resp_valid <= 1'b0;
            resp_dz    <= 1'b0;
            resp_ill   <= 1'b0;
            if (w_start) begin
                grant       <= NREQ'(1) << w_win;
                alu_data1   <= w_d1;
                alu_data2   <= w_d2;
                alu_shamt   <= w_shamt;
                alu_op      <= (w_dz || w_ill) ? OP_NOP : w_op;
                r_last      <= w_win;
                resp_id     <= w_win;
                r_cnt       <= (w_muldiv && !w_dz) ? CNTW'(MULDIV_LAT-1) : '0;
                r_icpt      <= w_dz || w_ill;
                r_icpt_data <= w_ill ? 32'd0 : ((w_op == OP_DIV) ? 32'hFFFF_FFFF : w_d1);
                r_dz        <= w_dz;
                r_ill       <= w_ill;
            end else if ((r_state == S_EXEC) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNTW'(1);
            end
            // Intercepted ops substitute their precomputed answer for the ALU's.
            if (w_done) begin
                resp_valid <= 1'b1;
                resp_data  <= r_icpt ? r_icpt_data : alu_out;
                resp_zero  <= r_icpt ? (r_icpt_data == 32'd0) : alu_zero;
                resp_dz    <= r_dz;
                resp_ill   <= r_ill;
            end
        end
    end
endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler: directed requests push expected responses,
// a negedge monitor pops and compares every resp_valid strobe.
module tb_alu_scheduler;
    localparam int NREQ = 2;
    localparam int LAT  = 4;
    localparam int IDW  = 3;
    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_MUL = 5'b01100;
    localparam logic [4:0] OP_DIV = 5'b01101;
    localparam logic [4:0] OP_REM = 5'b01110;

    logic                clock = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [5*NREQ-1:0]   req_op, req_shamt;
    logic [32*NREQ-1:0]  req_data1, req_data2;
    logic [NREQ-1:0]     grant;
    logic [31:0]         alu_data1, alu_data2, alu_out, resp_data;
    logic [4:0]          alu_op, alu_shamt;
    logic                alu_zero, resp_valid, resp_zero, resp_dz, resp_ill, busy;
    logic [IDW-1:0]      resp_id;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        zero;
        logic        dz;
        logic        ill;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    alu_scheduler #(.NREQ(NREQ), .MULDIV_LAT(LAT), .IDW(IDW)) dut (
        .clock(clock), .reset(reset), .req(req), .req_op(req_op),
        .req_data1(req_data1), .req_data2(req_data2), .req_shamt(req_shamt),
        .grant(grant), .alu_data1(alu_data1), .alu_data2(alu_data2),
        .alu_op(alu_op), .alu_shamt(alu_shamt), .alu_out(alu_out),
        .alu_zero(alu_zero), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_data(resp_data), .resp_zero(resp_zero), .resp_dz(resp_dz),
        .resp_ill(resp_ill), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Stand-in ALU; the default value is a poison pattern so an unintercepted case shows up.
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_out = alu_data1 + alu_data2;
            OP_MUL:  alu_out = alu_data1 * alu_data2;
            OP_DIV:  alu_out = (alu_data2 != 0) ? alu_data1 / alu_data2 : 32'hDEAD_BEEF;
            OP_REM:  alu_out = (alu_data2 != 0) ? alu_data1 % alu_data2 : 32'hDEAD_BEEF;
            default: alu_out = 32'h5A5A_5A5A;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_exp(input int id, input logic [31:0] data, input logic dz,
                            input logic ill, input int lat);
        exp_t e;
        e.id = id; e.data = data; e.zero = (data == 32'd0);
        e.dz = dz; e.ill = ill; e.cyc = cyc + lat;
        sb.push_back(e);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (resp_valid) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("resp_id", 64'(resp_id), 64'(e.id));
                check("resp_data", 64'(resp_data), 64'(e.data));
                check("resp_zero", 64'(resp_zero), 64'(e.zero));
                check("resp_dz", 64'(resp_dz), 64'(e.dz));
                check("resp_ill", 64'(resp_ill), 64'(e.ill));
                check("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic set_fields(input int idx, input logic [4:0] op, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [4:0] sh);
        req_op[5*idx +: 5]     = op;
        req_data1[32*idx +: 32] = d1;
        req_data2[32*idx +: 32] = d2;
        req_shamt[5*idx +: 5]  = sh;
    endtask

    task automatic issue(input int idx, input logic [4:0] op, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [4:0] sh,
                         input logic [31:0] edata, input logic edz, input logic eill);
        int         lat;
        logic [4:0] aop;
        @(negedge clock);
        req = '0;
        req[idx] = 1'b1;
        set_fields(idx, op, d1, d2, sh);
        @(negedge clock);
        check("grant", 64'(grant), 64'd1 << idx);
        req = '0;
        lat = ((op == OP_MUL || op == OP_DIV || op == OP_REM) && !edz) ? LAT : 1;
        aop = (edz || eill) ? 5'b00000 : op;
        push_exp(idx, edata, edz, eill, lat);
        for (int i = 0; i < lat; i++) begin
            check("busy", 64'(busy), 64'd1);
            check("alu_op", 64'(alu_op), 64'(aop));
            check("alu_data1", 64'(alu_data1), 64'(d1));
            check("alu_data2", 64'(alu_data2), 64'(d2));
            check("alu_shamt", 64'(alu_shamt), 64'(sh));
            check("flags_quiet", 64'({resp_dz, resp_ill}), 64'd0);
            @(negedge clock);
        end
        check("busy_end", 64'(busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = '0; req_op = '0; req_shamt = '0; req_data1 = '0; req_data2 = '0;
        repeat (3) @(negedge clock);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(resp_valid), 64'd0);
        check("rst_alu", 64'({alu_op, alu_data1}), 64'd0);
        reset = 1'b0;

        issue(0, OP_ADD, 32'd5, 32'd7, 5'd3, 32'd12, 1'b0, 1'b0);
        issue(1, OP_MUL, 32'd6, 32'd7, 5'd0, 32'd42, 1'b0, 1'b0);

        // Both requesters held high: grants alternate starting at requester 0.
        @(negedge clock);
        set_fields(0, OP_ADD, 32'd1, 32'd1, 5'd0);
        set_fields(1, OP_ADD, 32'd2, 32'd3, 5'd0);
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("rr_grant", 64'(grant), 64'd1 << (k % 2));
            push_exp(k % 2, (k % 2) ? 32'd5 : 32'd2, 1'b0, 1'b0, 1);
            if (k == 3) req = '0;
            @(negedge clock);
            check("rr_gap", 64'(grant), 64'd0);
        end

        issue(0, OP_DIV, 32'd9, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        issue(1, OP_REM, 32'd9, 32'd0, 5'd0, 32'd9, 1'b1, 1'b0);
        issue(0, 5'b10111, 32'd3, 32'd4, 5'd0, 32'd0, 1'b0, 1'b1);
        issue(1, OP_ADD, 32'd5, 32'hFFFF_FFFB, 5'd0, 32'd0, 1'b0, 1'b0);
        issue(0, OP_REM, 32'd100, 32'd7, 5'd2, 32'd2, 1'b0, 1'b0);

        // Abandon a divide mid-execution; pointer must fall back to favour requester 0.
        @(negedge clock);
        set_fields(0, OP_DIV, 32'd100, 32'd5, 5'd0);
        req = 2'b01;
        @(negedge clock);
        check("div_grant", 64'(grant), 64'd1);
        req = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_valid", 64'(resp_valid), 64'd0);
        check("mid_rst_alu", 64'({alu_op, alu_data1, alu_data2}), 64'd0);
        check("mid_rst_resp", 64'({resp_data, resp_id}), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < LAT + 1; i++) begin
            @(negedge clock);
            check("no_resp", 64'(resp_valid), 64'd0);
        end
        set_fields(0, OP_ADD, 32'd1, 32'd1, 5'd0);
        set_fields(1, OP_ADD, 32'd2, 32'd3, 5'd0);
        req = 2'b11;
        @(negedge clock);
        check("post_rst_grant", 64'(grant), 64'd1);
        push_exp(0, 32'd2, 1'b0, 1'b0, 1);
        req = '0;
        repeat (4) @(negedge clock);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
